// File: rtl/pattern_detect_ctrl.sv
// Serial pattern detector with a session controller: IDLE/RUN/DONE FSM that
// counts matches of a configurable up-to-PAT_W-bit pattern until a target or abort.
module pattern_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_wr,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W)-1:0]   cfg_len,
  input  logic                       cfg_overlap,
  input  logic [CNT_W-1:0]           cfg_target,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       valid_in,
  input  logic                       d_in,
  output logic                       pattern_detected,
  output logic [CNT_W-1:0]           match_count,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int LEN_W  = $clog2(PAT_W);
  localparam int SEEN_W = $clog2(PAT_W + 1);
  localparam logic [SEEN_W-1:0] SEEN_ONE  = SEEN_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [PAT_W-1:0]     hist_r, pat_r;
  logic [SEEN_W-1:0]    seen_r;
  logic [LEN_W-1:0]     len_r;
  logic                 ovl_r;
  logic [CNT_W-1:0]     tgt_r, count_r;
  logic                 det_r, done_r, busy_r, cfg_err_r;
  logic                 det_s, done_s, busy_s, cfg_err_s;
  logic                 sample_s, match_s, hit_s;
  logic [PAT_W-1:0]     hist_shift_s;
  logic [SEEN_W-1:0]    need_s, seen_inc_s;
  logic [CNT_W-1:0]     count_inc_s;

  // Compare only the low len+1 bits of history against the pattern.
  function automatic logic masked_eq(input logic [PAT_W-1:0] hist,
                                     input logic [PAT_W-1:0] pat,
                                     input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] mask;
    mask = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      if (i <= int'(len)) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
    return ((hist ^ pat) & mask) == {PAT_W{1'b0}};
  endfunction

  // Match evaluation includes the bit being sampled on this edge.
  always_comb begin
    sample_s     = (state_r == ST_RUN) && valid_in && !abort;
    hist_shift_s = {hist_r[PAT_W-2:0], d_in};
    need_s       = SEEN_W'(len_r) + SEEN_ONE;
    if (seen_r >= need_s) begin
      seen_inc_s = need_s;
    end else begin
      seen_inc_s = seen_r + SEEN_ONE;
    end
    match_s = sample_s && (seen_inc_s >= need_s) && masked_eq(hist_shift_s, pat_r, len_r);
    if (count_r == CNT_MAX) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + CNT_ONE;
    end
    hit_s = match_s && (tgt_r != CNT_ZERO) && (count_inc_s == tgt_r);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort always beats start and target completion.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (hit_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode, registered below so every output is a flop.
  always_comb begin
    det_s     = match_s;
    done_s    = (state_s == ST_DONE);
    busy_s    = (state_s == ST_RUN);
    cfg_err_s = cfg_wr && (state_r != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      det_r     <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      det_r     <= det_s;
      done_r    <= done_s;
      busy_r    <= busy_s;
      cfg_err_r <= cfg_err_s;
    end
  end

  // Configuration, history, bits-seen and match counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r   <= {PAT_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      ovl_r   <= 1'b0;
      tgt_r   <= CNT_ZERO;
      hist_r  <= {PAT_W{1'b0}};
      seen_r  <= {SEEN_W{1'b0}};
      count_r <= CNT_ZERO;
    end else begin
      if (cfg_wr && (state_r == ST_IDLE)) begin
        pat_r <= cfg_pattern;
        len_r <= cfg_len;
        ovl_r <= cfg_overlap;
        tgt_r <= cfg_target;
      end
      if ((state_r == ST_IDLE) && (state_s == ST_RUN)) begin
        hist_r  <= {PAT_W{1'b0}};
        seen_r  <= {SEEN_W{1'b0}};
        count_r <= CNT_ZERO;
      end else if (sample_s) begin
        hist_r <= hist_shift_s;
        // Non-overlapping mode restarts the bit count so no completing bit is reused.
        if (match_s && !ovl_r) begin
          seen_r <= {SEEN_W{1'b0}};
        end else begin
          seen_r <= seen_inc_s;
        end
        if (match_s) begin
          count_r <= count_inc_s;
        end
      end
    end
  end

  assign pattern_detected = det_r;
  assign match_count      = count_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign cfg_err          = cfg_err_r;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Self-checking bench for pattern_detect_ctrl: vector tables, directed corner
// sequences and randomized streams against a bit-history reference model.
module tb_pattern_detect_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, cfg_wr, cfg_overlap, start, abort, valid_in, d_in;
  logic [PAT_W-1:0] cfg_pattern;
  logic [2:0]       cfg_len;
  logic [CNT_W-1:0] cfg_target;
  logic             pattern_detected, busy, done, cfg_err;
  logic [CNT_W-1:0] match_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       vin;
    logic       d;
    logic       det;
    logic [7:0] cnt;
    logic       bsy;
    logic       dn;
  } vec_t;
  vec_t vq[$];

  // Reference model state: full session bit history plus bookkeeping.
  bit        m_bits[$];
  int        m_last_end;
  int        m_cnt;
  bit [7:0]  m_pat;
  int        m_len1;
  bit        m_ovl;

  always #5 clk = ~clk;

  pattern_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort), .valid_in(valid_in), .d_in(d_in),
    .pattern_detected(pattern_detected), .match_count(match_count),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; cfg_wr = 1'b0; start = 1'b0; abort = 1'b0;
    valid_in = 1'b0; d_in = 1'b0;
  endtask

  task automatic cfg_start(input logic [7:0] pat, input logic [2:0] len,
                           input logic ovl, input logic [7:0] tgt);
    cfg_wr = 1'b1; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ovl; cfg_target = tgt; start = 1'b1;
    step();
    cfg_wr = 1'b0; start = 1'b0;
  endtask

  task automatic send_bit(input logic d, input logic ab);
    valid_in = 1'b1; d_in = d; abort = ab;
    step();
    valid_in = 1'b0; abort = 1'b0;
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      valid_in = vq[i].vin; d_in = vq[i].d;
      step();
      valid_in = 1'b0;
      check({tag, "_det"},  pattern_detected, vq[i].det);
      check({tag, "_cnt"},  match_count,      vq[i].cnt);
      check({tag, "_busy"}, busy,             vq[i].bsy);
      check({tag, "_done"}, done,             vq[i].dn);
    end
    vq.delete();
  endtask

  function automatic void model_reset(input bit [7:0] pat, input int len, input bit ovl);
    m_bits.delete();
    m_last_end = 0; m_cnt = 0;
    m_pat = pat; m_len1 = len + 1; m_ovl = ovl;
  endfunction

  // A match is the newest len+1 bits equal to the pattern (pattern bit k = k-th newest),
  // using only bits after the previous match in non-overlapping mode.
  function automatic bit model_push(input bit d);
    int  n;
    int  avail;
    bit  hit;
    m_bits.push_back(d);
    n = m_bits.size();
    avail = m_ovl ? n : (n - m_last_end);
    hit = (avail >= m_len1);
    for (int k = 0; k < m_len1 && hit; k++) begin
      if (m_bits[n - 1 - k] != m_pat[k]) hit = 1'b0;
    end
    if (hit) begin
      if (m_cnt < 255) m_cnt++;
      m_last_end = n;
    end
    return hit;
  endfunction

  task automatic rand_session(input bit [7:0] pat, input int len, input bit ovl, input int nbits);
    int  sent;
    int  dut_pulses;
    int  ref_pulses;
    bit  vin;
    bit  d;
    bit  exp;
    cfg_start(pat, 3'(len), ovl, 8'd0);
    model_reset(pat, len, ovl);
    sent = 0; dut_pulses = 0; ref_pulses = 0;
    while (sent < nbits) begin
      vin = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom_range(0, 1));
      valid_in = vin; d_in = d;
      step();
      valid_in = 1'b0;
      exp = 1'b0;
      if (vin) begin
        exp = model_push(d);
        sent++;
      end
      if (exp) ref_pulses++;
      if (pattern_detected === 1'b1) dut_pulses++;
      check("rand_det", pattern_detected, exp);
    end
    step();
    check("rand_pulses", dut_pulses, ref_pulses);
    check("rand_count", match_count, m_cnt);
    check("rand_busy", busy, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    idle_inputs();
    cfg_pattern = 8'd0; cfg_len = 3'd0; cfg_overlap = 1'b0; cfg_target = 8'd0;

    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_det", pattern_detected, 1'b0);
    check("rst_cnt", match_count, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);

    // Pattern 1011, overlapping, stream 1,0,1,1,0,1,1
    cfg_start(8'h0B, 3'd3, 1'b1, 8'd0);
    check("ovl_start_busy", busy, 1'b1);
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0});
    run_vecs("ovl");
    abort = 1'b1; step(); abort = 1'b0;
    check("ovl_abort_busy", busy, 1'b0);
    check("ovl_idle_cnt_hold", match_count, 8'd2);

    // Same stream, non-overlapping
    cfg_start(8'h0B, 3'd3, 1'b0, 8'd0);
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0});
    run_vecs("novl");
    abort = 1'b1; step(); abort = 1'b0;

    // Pattern 11, target 3, gaps between bits, DONE then IDLE
    cfg_start(8'h03, 3'd1, 1'b1, 8'd3);
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'd1 - 8'd1, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0});
    run_vecs("tgt");

    // cfg_wr during RUN is rejected; abort on completing bit discards the match
    cfg_start(8'h0B, 3'd3, 1'b1, 8'd0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    cfg_wr = 1'b1; cfg_pattern = 8'hFF; cfg_len = 3'd7; step(); cfg_wr = 1'b0;
    check("run_cfg_err", cfg_err, 1'b1);
    step();
    check("run_cfg_err_clr", cfg_err, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("old_pat_det", pattern_detected, 1'b1);
    check("old_pat_cnt", match_count, 8'd1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    check("abort_det", pattern_detected, 1'b0);
    check("abort_cnt", match_count, 8'd1);
    check("abort_busy", busy, 1'b0);
    step();
    check("abort_done", done, 1'b0);

    // abort and start together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 1'b0);

    // Reset mid-session after one match
    cfg_start(8'h0B, 3'd3, 1'b1, 8'd0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    check("pre_rst_cnt", match_count, 8'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("mrst_det", pattern_detected, 1'b0);
    check("mrst_cnt", match_count, 8'd0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_cfg_err", cfg_err, 1'b0);
    step();
    check("mrst_idle_busy", busy, 1'b0);

    // Randomized streams against the reference model
    rand_session(8'h0B, 3, 1'b1, 500);
    rand_session(8'h0B, 3, 1'b0, 300);
    for (int s = 0; s < 4; s++) begin
      rand_session(8'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)), 200);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
